// File: rtl/trace_chk_pkg.sv
// Shared types for the instruction-trace checker: FSM states, per-entry
// verdicts and finish-cause encodings.
package trace_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } chk_state_e;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_PASS = 2'b01,
        RES_FAIL = 2'b10,
        RES_MISS = 2'b11
    } chk_res_e;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_HALT    = 2'b01;
    localparam logic [1:0] CAUSE_FAIL    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    function automatic chk_res_e judge(input logic ok);
        return ok ? RES_PASS : RES_FAIL;
    endfunction

endpackage

// File: rtl/trace_chk_table.sv
// Checkpoint table: DEPTH entries of {num_inst, expected port}, one write
// port, asynchronous read. Contents are deliberately not reset.
module trace_chk_table #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 64,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IW-1:0]     widx_i,
    input  logic [WORD_W-1:0] wnum_i,
    input  logic [WORD_W-1:0] wans_i,
    input  logic [IW-1:0]     ridx_i,
    output logic [WORD_W-1:0] rnum_o,
    output logic [WORD_W-1:0] rans_o
);

    logic [2*WORD_W-1:0] mem_q [DEPTH];

    // Table write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[widx_i] <= {wnum_i, wans_i};
        end
    end

    assign {rnum_o, rans_o} = mem_q[ridx_i];

endmodule

// File: rtl/inst_trace_checker.sv
// Self-checking CPU trace monitor: compares output_port against a table of
// (instruction count, expected value) checkpoints and reports the outcome.
module inst_trace_checker
    import trace_chk_pkg::*;
#(
    parameter int WORD_W       = 16,
    parameter int DEPTH        = 64,
    parameter int CYC_W        = 16,
    parameter int MAX_CYCLES   = 10000,
    parameter int STOP_ON_FAIL = 1,
    parameter int SAMPLE_LAST  = 1,
    localparam int IW          = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              cfg_we_i,
    input  logic [IW-1:0]     cfg_idx_i,
    input  logic [WORD_W-1:0] cfg_num_inst_i,
    input  logic [WORD_W-1:0] cfg_ans_i,
    input  logic [IW:0]       cfg_count_i,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic [WORD_W-1:0] num_inst_i,
    input  logic [WORD_W-1:0] output_port_i,
    input  logic              is_halted_i,
    output logic              running_o,
    output logic              done_o,
    output logic [IW:0]       pass_cnt_o,
    output logic [IW:0]       fail_cnt_o,
    output logic [IW:0]       miss_cnt_o,
    output logic              all_pass_o,
    output logic [IW-1:0]     first_fail_idx_o,
    output logic [WORD_W-1:0] first_fail_got_o,
    output logic [1:0]        finish_cause_o,
    output logic [CYC_W-1:0]  cycle_cnt_o
);

    chk_state_e        state_q;
    logic              running_q, done_q, all_pass_q;
    logic [IW:0]       count_q, ptr_q, pass_q, fail_q, miss_q;
    logic [IW:0]       ptr_d, pass_d, fail_d, miss_d;
    logic              pend_q, pend_d, ok_q, ok_d;
    logic [WORD_W-1:0] got_q, got_d;
    logic [IW-1:0]     ff_idx_q;
    logic [WORD_W-1:0] ff_got_q;
    logic [1:0]        cause_q;
    logic [CYC_W-1:0]  cycle_q;

    logic [WORD_W-1:0] e_num_s, e_ans_s, res_got_s;
    logic              entry_vld_s, hit_s, ahead_s, port_ok_s, first_fail_s, tbl_we_s;
    chk_res_e          res_s;

    assign tbl_we_s = cfg_we_i && (state_q == ST_IDLE);

    trace_chk_table #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_table (
        .clk_i  (clk_i),
        .we_i   (tbl_we_s),
        .widx_i (cfg_idx_i),
        .wnum_i (cfg_num_inst_i),
        .wans_i (cfg_ans_i),
        .ridx_i (ptr_q[IW-1:0]),
        .rnum_o (e_num_s),
        .rans_o (e_ans_s)
    );

    assign entry_vld_s = (ptr_q < count_q);
    assign hit_s       = (num_inst_i == e_num_s);
    assign ahead_s     = (num_inst_i > e_num_s);
    assign port_ok_s   = (output_port_i == e_ans_s);

    // Verdict for the entry at ptr this cycle, plus the last-sample tracking
    always_comb begin
        res_s     = RES_NONE;
        res_got_s = output_port_i;
        pend_d    = pend_q;
        ok_d      = ok_q;
        got_d     = got_q;
        if (entry_vld_s) begin
            if (SAMPLE_LAST == 0) begin
                if (hit_s) begin
                    res_s = judge(port_ok_s);
                end else if (ahead_s) begin
                    res_s = RES_MISS;
                end else begin
                    res_s = RES_NONE;
                end
            end else begin
                // A halt on a matching cycle makes this sample the last one.
                if (hit_s) begin
                    if (is_halted_i) begin
                        res_s  = judge(port_ok_s);
                        pend_d = 1'b0;
                    end else begin
                        pend_d = 1'b1;
                        ok_d   = port_ok_s;
                        got_d  = output_port_i;
                    end
                end else if (pend_q) begin
                    res_s     = judge(ok_q);
                    res_got_s = got_q;
                    pend_d    = 1'b0;
                end else if (ahead_s) begin
                    res_s = RES_MISS;
                end else begin
                    res_s = RES_NONE;
                end
            end
        end else begin
            res_s = RES_NONE;
        end
    end

    assign ptr_d        = ptr_q  + (IW+1)'(res_s != RES_NONE);
    assign pass_d       = pass_q + (IW+1)'(res_s == RES_PASS);
    assign fail_d       = fail_q + (IW+1)'(res_s == RES_FAIL);
    assign miss_d       = miss_q + (IW+1)'(res_s == RES_MISS);
    assign first_fail_s = (res_s == RES_FAIL) && (fail_q == {(IW+1){1'b0}});

    // Checker FSM with all result registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            all_pass_q <= 1'b0;
            count_q    <= {(IW+1){1'b0}};
            ptr_q      <= {(IW+1){1'b0}};
            pass_q     <= {(IW+1){1'b0}};
            fail_q     <= {(IW+1){1'b0}};
            miss_q     <= {(IW+1){1'b0}};
            pend_q     <= 1'b0;
            ok_q       <= 1'b0;
            got_q      <= {WORD_W{1'b0}};
            ff_idx_q   <= {IW{1'b0}};
            ff_got_q   <= {WORD_W{1'b0}};
            cause_q    <= CAUSE_NONE;
            cycle_q    <= {CYC_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q    <= ST_RUN;
                        running_q  <= 1'b1;
                        done_q     <= 1'b0;
                        all_pass_q <= 1'b0;
                        count_q    <= cfg_count_i;
                        ptr_q      <= {(IW+1){1'b0}};
                        pass_q     <= {(IW+1){1'b0}};
                        fail_q     <= {(IW+1){1'b0}};
                        miss_q     <= {(IW+1){1'b0}};
                        pend_q     <= 1'b0;
                        ok_q       <= 1'b0;
                        got_q      <= {WORD_W{1'b0}};
                        ff_idx_q   <= {IW{1'b0}};
                        ff_got_q   <= {WORD_W{1'b0}};
                        cause_q    <= CAUSE_NONE;
                        cycle_q    <= {CYC_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    cycle_q <= cycle_q + CYC_W'(1);
                    ptr_q   <= ptr_d;
                    pass_q  <= pass_d;
                    fail_q  <= fail_d;
                    miss_q  <= miss_d;
                    pend_q  <= pend_d;
                    ok_q    <= ok_d;
                    got_q   <= got_d;
                    if (first_fail_s) begin
                        ff_idx_q <= ptr_q[IW-1:0];
                        ff_got_q <= res_got_s;
                    end
                    // Finish priority: stopping fail, then halt, then budget.
                    if ((STOP_ON_FAIL != 0) && (res_s == RES_FAIL)) begin
                        state_q    <= ST_DONE;
                        running_q  <= 1'b0;
                        done_q     <= 1'b1;
                        cause_q    <= CAUSE_FAIL;
                        all_pass_q <= (pass_d == count_q);
                    end else if (is_halted_i) begin
                        state_q    <= ST_DONE;
                        running_q  <= 1'b0;
                        done_q     <= 1'b1;
                        cause_q    <= CAUSE_HALT;
                        all_pass_q <= (pass_d == count_q);
                    end else if (cycle_q == CYC_W'(MAX_CYCLES - 1)) begin
                        state_q    <= ST_DONE;
                        running_q  <= 1'b0;
                        done_q     <= 1'b1;
                        cause_q    <= CAUSE_TIMEOUT;
                        all_pass_q <= (pass_d == count_q);
                    end
                end
                ST_DONE: begin
                    if (clear_i) begin
                        state_q    <= ST_IDLE;
                        done_q     <= 1'b0;
                        all_pass_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign running_o        = running_q;
    assign done_o           = done_q;
    assign pass_cnt_o       = pass_q;
    assign fail_cnt_o       = fail_q;
    assign miss_cnt_o       = miss_q;
    assign all_pass_o       = all_pass_q;
    assign first_fail_idx_o = ff_idx_q;
    assign first_fail_got_o = ff_got_q;
    assign finish_cause_o   = cause_q;
    assign cycle_cnt_o      = cycle_q;

endmodule
